// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: default window base,
// response FSM encoding and the byte-strobe expansion helper.
package mem_pkg;

    localparam logic [31:0] DEFAULT_BASE = 32'h80000000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } resp_state_t;

    // Expand a 4-bit byte strobe into a 32-bit bit mask (bit i -> byte lane i).
    function automatic logic [31:0] strb_mask(input logic [3:0] strb);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) begin
            m[8*i +: 8] = {8{strb[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between a load/store (or fetch) requester and the
// memory responder.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The request side holds req_* stable only while it wants the
// request taken; anything presented while req_ready=0 is ignored. The
// response side holds resp_rdata/resp_err stable while resp_valid=1 and
// resp_ready=0.
interface mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_wen, req_addr, req_wdata, req_wstrb, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata, req_wstrb, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/mem_array.sv
// Word array with byte write mask and combinational read. Contents are
// not reset; the simulator may load images into mem hierarchically.
module mem_array #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic [31:0]       wmask,
    output logic [31:0]       rdata
);

    logic [31:0] mem [2**ADDR_W];

    // Masked write: only bits selected by wmask take the new data.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= (mem[addr] & ~wmask) | (wdata & wmask);
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder: accepts a read or byte-strobed write,
// commits it on the edge entering RESP and presents the response LATENCY
// cycles after acceptance.
module mem_responder
    import mem_pkg::*;
#(
    parameter logic [31:0] BASE    = DEFAULT_BASE,
    parameter int          ADDR_W  = 16,
    parameter int          LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst,
    mem_responder_if.slave   bus,
    output resp_state_t      state
);

    localparam logic [32:0] SPAN     = 33'd4 << ADDR_W;
    localparam logic [3:0]  CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    resp_state_t next_state;
    logic [3:0]  cnt;
    logic [3:0]  next_cnt;
    logic        commit;

    logic        op_wen;
    logic [31:0] op_addr;
    logic [31:0] op_wdata;
    logic [3:0]  op_wstrb;

    logic        cur_wen;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    logic [3:0]  cur_wstrb;
    logic [31:0] off;
    logic        in_range;
    logic [31:0] mem_rdata;

    logic [31:0] rdata;
    logic        err;

    // With LATENCY=1 the commit edge is the acceptance edge, so the live
    // request is used in IDLE; otherwise the latched copy is used.
    assign cur_wen   = (state == IDLE) ? bus.req_wen   : op_wen;
    assign cur_addr  = (state == IDLE) ? bus.req_addr  : op_addr;
    assign cur_wdata = (state == IDLE) ? bus.req_wdata : op_wdata;
    assign cur_wstrb = (state == IDLE) ? bus.req_wstrb : op_wstrb;

    // Unsigned wraparound makes addresses below BASE land far out of range.
    assign off      = cur_addr - BASE;
    assign in_range = ({1'b0, off} < SPAN);

    mem_array #(.ADDR_W(ADDR_W)) u_array (
        .clk   (clk),
        .we    (commit && cur_wen && in_range),
        .addr  (off[ADDR_W+1:2]),
        .wdata (cur_wdata),
        .wmask (strb_mask(cur_wstrb)),
        .rdata (mem_rdata)
    );

    // State and latency counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    // Next-state, counter and commit decode.
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    if (LATENCY == 1) begin
                        next_state = RESP;
                        commit     = 1'b1;
                    end else begin
                        next_state = WAIT;
                        next_cnt   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    next_state = RESP;
                    commit     = 1'b1;
                end else begin
                    next_cnt = cnt - 4'd1;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Capture the request on acceptance; it is held until the commit edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_wen   <= 1'b0;
            op_addr  <= 32'd0;
            op_wdata <= 32'd0;
            op_wstrb <= 4'd0;
        end else if (state == IDLE && bus.req_valid) begin
            op_wen   <= bus.req_wen;
            op_addr  <= bus.req_addr;
            op_wdata <= bus.req_wdata;
            op_wstrb <= bus.req_wstrb;
        end
    end

    // Response data/error: loaded at commit, held through RESP, cleared on
    // the response handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= 32'd0;
            err   <= 1'b0;
        end else if (commit) begin
            rdata <= (!cur_wen && in_range) ? mem_rdata : 32'd0;
            err   <= !in_range;
        end else if (state == RESP && bus.resp_ready) begin
            rdata <= 32'd0;
            err   <= 1'b0;
        end
    end

    assign bus.req_ready  = (state == IDLE);
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_rdata = rdata;
    assign bus.resp_err   = err;

endmodule
